// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared types for the bit-serial subtractor controller.
// State encoding; 2'd3 is illegal and recovers to IDLE.
package serial_subtractor_ctrl_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_BAD  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    RUN  = S_RUN,
    DONE = S_DONE,
    BAD  = S_BAD
  } state_e;

endpackage

// File: rtl/serial_subtractor_ctrl_if.sv
// Host handshake bundle: start/a/b in, busy/done/diff/borrow_out out.
// master = host side, slave = controller side.
interface serial_subtractor_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: diff = a-b-bin, bout = borrow.
// Ports: a, b, bin in; diff, bout out.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a-b controller, LSB first, one shared subtractor cell.
// Ports: clk, rst (sync, high), bus (slave handshake bundle).
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_subtractor_ctrl_if.slave bus
);
  import serial_subtractor_ctrl_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nx;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             d;
  logic             bout;
  logic             busy_q;
  logic             done_q;
  logic             bo_q;

  full_subtractor_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (brw),
    .diff (d),
    .bout (bout)
  );

  generate
    if (WIDTH == 1) begin : g_one
      assign res_nx = d;
    end else begin : g_many
      assign res_nx = {d, res_sh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      diff_q <= '0;
      cnt    <= '0;
      brw    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bo_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            brw    <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nx;
          brw    <= bout;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            diff_q <= res_nx;
            bo_q   <= bout;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bo_q;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl at WIDTH 8 and 1.
// Model predicts results and timing from accept edges.
module tb_serial_subtractor_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_subtractor_ctrl_if #(.WIDTH(8)) i8 ();
  serial_subtractor_ctrl_if #(.WIDTH(1)) i1 ();

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (i8.slave)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (i1.slave)
  );

  typedef struct {
    bit [7:0] d;
    bit       b;
    int       ed;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];

  int cyc = 0;
  int npass = 0;
  int ntot = 0;

  int       acc[2];
  bit       act[2];
  bit [7:0] pd[2];
  bit [7:0] hd[2];
  bit       pb[2];
  bit       hb[2];

  task automatic chk(input string nm, input int av, input int ev);
    ntot++;
    if (av == ev) npass++;
    else $display("FAIL %s: got %0d expected %0d at edge %0d",
                  nm, av, ev, cyc - 1);
  endtask

  // Reference model: evaluated at each edge with the edge index.
  always @(posedge clk) begin
    int       w;
    bit       st;
    bit [7:0] av;
    bit [7:0] bv;
    bit [7:0] m;
    exp_t     x;
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      w  = (k == 0) ? 8 : 1;
      m  = (k == 0) ? 8'hFF : 8'h01;
      st = (k == 0) ? i8.start : i1.start;
      av = (k == 0) ? i8.a : {7'b0, i1.a};
      bv = (k == 0) ? i8.b : {7'b0, i1.b};
      if (rst) begin
        act[k] = 1'b0;
        hd[k]  = 8'h00;
        hb[k]  = 1'b0;
        if (k == 0) q8.delete();
        else q1.delete();
      end else begin
        if (act[k] && cyc == acc[k] + w) begin
          hd[k] = pd[k];
          hb[k] = pb[k];
        end
        if (st && (!act[k] || cyc >= acc[k] + w + 2)) begin
          act[k] = 1'b1;
          acc[k] = cyc;
          pd[k]  = (av - bv) & m;
          pb[k]  = av < bv;
          x.d  = pd[k];
          x.b  = pb[k];
          x.ed = cyc + w;
          if (k == 0) q8.push_back(x);
          else q1.push_back(x);
        end
      end
    end
  end

  // Monitor: compares outputs mid-cycle, pops on done.
  always @(negedge clk) begin
    int       l;
    int       w;
    bit       bz;
    bit       dn;
    bit [7:0] df;
    bit       bo;
    exp_t     x;
    l = cyc - 1;
    for (int k = 0; k < 2; k++) begin
      w  = (k == 0) ? 8 : 1;
      bz = (k == 0) ? i8.busy : i1.busy;
      dn = (k == 0) ? i8.done : i1.done;
      df = (k == 0) ? i8.diff : {7'b0, i1.diff};
      bo = (k == 0) ? i8.borrow_out : i1.borrow_out;
      chk($sformatf("w%0d_busy", w), int'(bz),
          int'(act[k] && l >= acc[k] && l < acc[k] + w));
      chk($sformatf("w%0d_done", w), int'(dn),
          int'(act[k] && l == acc[k] + w));
      chk($sformatf("w%0d_diff_hold", w), int'(df), int'(hd[k]));
      chk($sformatf("w%0d_borrow_hold", w), int'(bo), int'(hb[k]));
      chk($sformatf("w%0d_busy_and_done", w), int'(bz && dn), 0);
      if (dn) begin
        chk($sformatf("w%0d_done_expected", w),
            (k == 0) ? q8.size() : q1.size(), 1);
        if ((k == 0 && q8.size() > 0) || (k == 1 && q1.size() > 0)) begin
          x = (k == 0) ? q8.pop_front() : q1.pop_front();
          chk($sformatf("w%0d_sb_diff", w), int'(df), int'(x.d));
          chk($sformatf("w%0d_sb_borrow", w), int'(bo), int'(x.b));
          chk($sformatf("w%0d_sb_latency", w), l, x.ed);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op8(input bit [7:0] a, input bit [7:0] b);
    i8.start = 1'b1;
    i8.a = a;
    i8.b = b;
    tick();
    i8.start = 1'b0;
    repeat (12) tick();
  endtask

  task automatic op1(input bit a, input bit b);
    i1.start = 1'b1;
    i1.a = a;
    i1.b = b;
    tick();
    i1.start = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b1;
    i8.start = 1'b0;
    i8.a = '0;
    i8.b = '0;
    i1.start = 1'b0;
    i1.a = '0;
    i1.b = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    op8(8'h5A, 8'h3C);
    op8(8'h00, 8'h01);
    op8(8'h80, 8'h80);

    i8.start = 1'b1;
    i8.a = 8'hC3;
    i8.b = 8'hD4;
    repeat (40) tick();
    i8.start = 1'b0;
    repeat (12) tick();

    i8.start = 1'b1;
    i8.a = 8'h5A;
    i8.b = 8'h3C;
    tick();
    i8.start = 1'b0;
    repeat (3) tick();
    i8.start = 1'b1;
    i8.a = 8'hFF;
    i8.b = 8'h01;
    tick();
    i8.start = 1'b0;
    repeat (10) tick();

    i8.start = 1'b1;
    i8.a = 8'h77;
    i8.b = 8'h99;
    tick();
    i8.start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    op8(8'h10, 8'h0F);

    op1(1'b0, 1'b0);
    op1(1'b0, 1'b1);
    op1(1'b1, 1'b0);
    op1(1'b1, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      i8.start = ($urandom_range(0, 3) == 0);
      i8.a = 8'($urandom);
      i8.b = 8'($urandom);
      i1.start = ($urandom_range(0, 2) == 0);
      i1.a = 1'($urandom);
      i1.b = 1'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    i8.start = 1'b0;
    i1.start = 1'b0;
    repeat (15) tick();

    chk("q8_drained", q8.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
